// File: rtl/bitwise_logic_pipe_if.sv
// ---------------------------------------------------------------------------
// bitwise_logic_pipe_if
// Handshake bundle for the bitwise logic-ops unit.
//   Input side : in_valid/in_ready, a, b, op, acc_use
//   Output side: out_valid/out_ready, result, zero, all_ones, popcnt
// master = producer/consumer around the unit, slave = the unit itself.
// ---------------------------------------------------------------------------
interface bitwise_logic_pipe_if #(
  parameter int WIDTH = 64
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_use;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             all_ones;
  logic [CNT_W-1:0] popcnt;

  modport master (
    output in_valid, a, b, op, acc_use, out_ready,
    input  in_ready, out_valid, result, zero, all_ones, popcnt
  );

  modport slave (
    input  in_valid, a, b, op, acc_use, out_ready,
    output in_ready, out_valid, result, zero, all_ones, popcnt
  );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// ---------------------------------------------------------------------------
// bitwise_logic_pipe
// Two-stage bitwise logic unit with optional accumulator operand and
// registered result flags.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : bitwise_logic_pipe_if.slave
//           in_valid/in_ready accept a, b, op, acc_use
//           out_valid/out_ready deliver result, zero, all_ones, popcnt
// op: 000 X&B, 001 X|B, 010 X^B, 011 ~(X|B), 100 ~(X&B), 101 ~(X^B),
//     110 X&~B, 111 B      where X = acc_use ? acc : a
// ---------------------------------------------------------------------------

// Single bit slice of the operation mux.
module blp_lane (
  input  logic       i_x,
  input  logic       i_b,
  input  logic [2:0] i_op,
  output logic       o_r
);
  always_comb begin
    o_r = 1'b0;
    unique case (i_op)
      3'b000: o_r = i_x & i_b;
      3'b001: o_r = i_x | i_b;
      3'b010: o_r = i_x ^ i_b;
      3'b011: o_r = ~(i_x | i_b);
      3'b100: o_r = ~(i_x & i_b);
      3'b101: o_r = ~(i_x ^ i_b);
      3'b110: o_r = i_x & ~i_b;
      3'b111: o_r = i_b;
      default: o_r = 1'b0;
    endcase
  end
endmodule

module bitwise_logic_pipe #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  bitwise_logic_pipe_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  // stage 1
  logic             r_v1;
  logic [WIDTH-1:0] r_r1;
  logic [WIDTH-1:0] r_acc;
  // stage 2 (output)
  logic             r_v2;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_all_ones;
  logic [CNT_W-1:0] r_popcnt;

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_r;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_move;
  logic [CNT_W-1:0] w_pc;

  assign w_x = bus.acc_use ? r_acc : bus.a;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    blp_lane u_lane (
      .i_x  (w_x[i]),
      .i_b  (bus.b[i]),
      .i_op (bus.op),
      .o_r  (w_r[i])
    );
  end

  // Stage 1 can take new data if empty, if stage 2 has room, or if stage 2
  // drains this cycle (then stage 1 moves forward on the same edge).
  assign w_in_ready = !reset && (!r_v1 || !r_v2 || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_move     = r_v1 && (!r_v2 || bus.out_ready);

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < WIDTH; i++)
      w_pc = w_pc + CNT_W'(r_r1[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1       <= 1'b0;
      r_r1       <= '0;
      r_acc      <= '0;
      r_v2       <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_all_ones <= 1'b0;
      r_popcnt   <= '0;
    end else begin
      // acc tracks the newest accepted result so acc_use chains without bubbles
      if (w_accept) begin
        r_v1  <= 1'b1;
        r_r1  <= w_r;
        r_acc <= w_r;
      end else if (w_move) begin
        r_v1  <= 1'b0;
      end

      if (w_move) begin
        r_v2       <= 1'b1;
        r_result   <= r_r1;
        r_zero     <= (r_r1 == '0);
        r_all_ones <= &r_r1;
        r_popcnt   <= w_pc;
      end else if (bus.out_ready) begin
        r_v2 <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_v2;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.all_ones  = r_all_ones;
  assign bus.popcnt    = r_popcnt;
endmodule

// File: tb/tb_bitwise_logic_pipe.sv
module tb_bitwise_logic_pipe;
  logic clk;
  logic reset;

  bitwise_logic_pipe_if #(.WIDTH(64)) b64 ();
  bitwise_logic_pipe_if #(.WIDTH(8))  b8  ();

  bitwise_logic_pipe #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .bus(b64.slave));
  bitwise_logic_pipe #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] r;
    logic        z;
    logic        ao;
    logic [6:0]  pc;
  } exp_t;

  exp_t q64[$];
  exp_t q8[$];
  logic [63:0] m_acc;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] r, input int w);
    exp_t e;
    logic [63:0] mask;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    e.r  = r & mask;
    e.z  = (e.r == 64'd0);
    e.ao = (e.r == mask);
    e.pc = 7'($countones(e.r));
    return e;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0: return x & b;
      3'd1: return x | b;
      3'd2: return x ^ b;
      3'd3: return ~(x | b);
      3'd4: return ~(x & b);
      3'd5: return ~(x ^ b);
      3'd6: return x & ~b;
      default: return b;
    endcase
  endfunction

  // Called at posedge+1. Returns at posedge+1 after the accepting edge.
  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic [2:0] op, input logic au);
    int n;
    logic [63:0] r;
    n = 0;
    b64.in_valid = 1'b1; b64.a = a; b64.b = b; b64.op = op; b64.acc_use = au;
    @(negedge clk);
    while (!b64.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!b64.in_ready) begin
      chk("send_timeout_in_ready", {63'd0, b64.in_ready}, 64'd1);
    end else begin
      @(posedge clk);
      r = model(au ? m_acc : a, b, op);
      m_acc = r;
      q64.push_back(mk(r, 64));
    end
    #1 b64.in_valid = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [7:0] er);
    int n;
    n = 0;
    b8.in_valid = 1'b1; b8.a = a; b8.b = b; b8.op = op; b8.acc_use = 1'b0;
    @(negedge clk);
    while (!b8.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!b8.in_ready) begin
      chk("send8_timeout_in_ready", {63'd0, b8.in_ready}, 64'd1);
    end else begin
      @(posedge clk);
      q8.push_back(mk({56'd0, er}, 8));
    end
    #1 b8.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q64.size() != 0 || q8.size() != 0) && n < 60) begin @(negedge clk); n++; end
    chk("drain_q64_empty", 64'(q64.size()), 64'd0);
    chk("drain_q8_empty", 64'(q8.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboards: compare on every output handshake.
  always @(negedge clk) begin
    if (!reset && b64.out_valid && b64.out_ready) begin
      if (q64.size() == 0) chk("m64_unexpected_out", {63'd0, b64.out_valid}, 64'd0);
      else begin
        exp_t e;
        e = q64.pop_front();
        chk("m64_result", b64.result, e.r);
        chk("m64_zero", {63'd0, b64.zero}, {63'd0, e.z});
        chk("m64_all_ones", {63'd0, b64.all_ones}, {63'd0, e.ao});
        chk("m64_popcnt", {57'd0, b64.popcnt}, {57'd0, e.pc});
      end
    end
    if (!reset && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) chk("m8_unexpected_out", {63'd0, b8.out_valid}, 64'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("m8_result", {56'd0, b8.result}, e.r);
        chk("m8_zero", {63'd0, b8.zero}, {63'd0, e.z});
        chk("m8_all_ones", {63'd0, b8.all_ones}, {63'd0, e.ao});
        chk("m8_popcnt", {60'd0, b8.popcnt}, {57'd0, e.pc});
      end
    end
  end

  logic [63:0] held;

  initial begin
    reset = 1'b1;
    m_acc = '0;
    b64.in_valid = 0; b64.a = '0; b64.b = '0; b64.op = '0; b64.acc_use = 0; b64.out_ready = 1;
    b8.in_valid  = 0; b8.a  = '0; b8.b  = '0; b8.op  = '0; b8.acc_use  = 0; b8.out_ready  = 1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, b64.in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, b64.out_valid}, 64'd0);
    chk("rst_result", b64.result, 64'd0);
    chk("rst_flags", {61'd0, b64.zero, b64.all_ones, 1'b0}, 64'd0);
    chk("rst_popcnt", {57'd0, b64.popcnt}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, b64.in_ready}, 64'd1);
    @(posedge clk); #1;

    // 1: single OR, latency 2
    send(64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 3'b001, 1'b0);
    @(negedge clk);
    chk("lat_e1_out_valid", {63'd0, b64.out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_e2_out_valid", {63'd0, b64.out_valid}, 64'd1);
    chk("t1_result", b64.result, 64'h0FFF_0FFF_0FFF_0FFF);
    chk("t1_popcnt", {57'd0, b64.popcnt}, 64'd48);
    @(posedge clk); #1;
    drain();

    // 2: op sweep back-to-back
    for (int op = 0; op < 8; op++) send(64'hA5, 64'h3C, 3'(op), 1'b0);
    drain();

    // 3: accumulator chain after reset
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0; m_acc = '0;
    send(64'd0, 64'd1, 3'b001, 1'b1);
    send(64'd0, 64'd2, 3'b001, 1'b1);
    send(64'd0, 64'd4, 3'b001, 1'b1);
    send(64'd0, 64'd8, 3'b001, 1'b1);
    send(64'd0, 64'd15, 3'b010, 1'b1);
    @(negedge clk); @(negedge clk);
    chk("t3_zero_flag", {63'd0, b64.zero}, 64'd1);
    drain();

    // 4: backpressure
    b64.out_ready = 1'b0;
    send(64'h1234, 64'h00F0, 3'b000, 1'b0);
    send(64'h1234, 64'h00F0, 3'b001, 1'b0);
    held = q64[0].r;
    b64.in_valid = 1'b1; b64.a = 64'h1234; b64.b = 64'h00F0; b64.op = 3'b010; b64.acc_use = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", {63'd0, b64.in_ready}, 64'd0);
      chk("bp_out_valid_held", {63'd0, b64.out_valid}, 64'd1);
      chk("bp_result_held", b64.result, held);
      @(posedge clk); #1;
    end
    b64.out_ready = 1'b1;
    send(64'h1234, 64'h00F0, 3'b010, 1'b0);
    drain();

    // 5: flags at WIDTH=8
    send8(8'h00, 8'hFF, 3'b111, 8'hFF);
    send8(8'h0F, 8'hF0, 3'b000, 8'h00);
    drain();

    // 6: reset mid-flight with acc != 0
    b64.out_ready = 1'b0;
    send(64'd0, 64'd9, 3'b111, 1'b0);
    send(64'd0, 64'd6, 3'b001, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    q64.delete(); m_acc = '0;
    chk("mid_rst_out_valid", {63'd0, b64.out_valid}, 64'd0);
    chk("mid_rst_result", b64.result, 64'd0);
    chk("mid_rst_popcnt", {57'd0, b64.popcnt}, 64'd0);
    reset = 1'b0; b64.out_ready = 1'b1;
    send(64'd0, 64'd5, 3'b001, 1'b1);
    @(negedge clk); @(negedge clk);
    chk("t6_result_acc_cleared", b64.result, 64'd5);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
